// File: rtl/note_sequence_controller.sv
// Records live key events (note, octave, duration in ticks) into a small event RAM and
// replays them as note/octave updates with a one-cycle load strobe for the datapath.
module note_sequence_controller #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 500000,
  parameter int DUR_W    = 10
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_key_valid,
  input  logic                   i_key_release,
  input  logic [3:0]             i_key_note,
  input  logic [1:0]             i_key_octave,
  input  logic                   i_record_en,
  input  logic                   i_play_req,
  input  logic                   i_stop,
  output logic [3:0]             o_note_out,
  output logic [1:0]             o_octave_out,
  output logic                   o_note_load,
  output logic                   o_note_on,
  output logic                   o_recording,
  output logic                   o_playing,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW = 6 + DUR_W;
  localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_MAX   = {DUR_W{1'b1}};
  localparam logic [3:0]       NOTE_REST = 4'hF;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REC   = 3'd1;
  localparam logic [2:0] S_PLOAD = 3'd2;
  localparam logic [2:0] S_PWAIT = 3'd3;
  localparam logic [2:0] S_PHOLD = 3'd4;

  logic [2:0]       r_state;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    r_idx;
  logic [TW-1:0]    r_tick_cnt;
  logic [DUR_W-1:0] r_dur_ctr;
  logic             r_pend_valid;
  logic             r_pend_rest;
  logic [3:0]       r_pend_note;
  logic [1:0]       r_pend_oct;
  logic [DUR_W-1:0] r_hold_cnt;
  logic [DUR_W-1:0] r_hold_dur;
  logic [3:0]       r_note_out;
  logic [1:0]       r_octave_out;
  logic             r_note_load;
  logic             r_note_on;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [EW-1:0]    r_rd_data;

  logic             w_tick;
  logic             w_full;
  logic             w_key_ok;
  logic             w_press;
  logic             w_rel_match;
  logic             w_rec_evt;
  logic             w_rec_end;
  logic             w_wr_en;
  logic             w_full_after;
  logic             w_open;
  logic [DUR_W-1:0] w_close_dur;
  logic [EW-1:0]    w_wr_data;
  logic             w_hold_done;
  logic             w_last;
  logic             w_play_abort;
  logic             w_play_end;
  logic [2:0]       w_state_next;
  logic [3:0]       w_rd_note;
  logic [1:0]       w_rd_oct;
  logic [DUR_W-1:0] w_rd_dur;

  assign w_tick      = (r_tick_cnt == TICK_LAST);
  assign w_full      = (r_count == DEPTH_C);
  assign w_key_ok    = i_key_valid && (i_key_note != NOTE_REST);
  assign w_press     = w_key_ok && !i_key_release;
  assign w_rel_match = w_key_ok && i_key_release && r_pend_valid && !r_pend_rest &&
                       (i_key_note == r_pend_note) && (i_key_octave == r_pend_oct);
  assign w_rec_evt   = (r_state == S_REC) && !i_stop && i_record_en && (w_press || w_rel_match);
  assign w_rec_end   = (r_state == S_REC) && !i_stop && !i_record_en;
  // A trailing rest is never stored when the session ends; only a held note is closed.
  assign w_wr_en      = !i_reset && !w_full && r_pend_valid &&
                        (w_rec_evt || (w_rec_end && !r_pend_rest));
  assign w_full_after = w_wr_en ? (r_count == DEPTH_C - 1'b1) : w_full;
  assign w_open       = w_rec_evt && !w_full_after;
  assign w_close_dur  = (r_dur_ctr == '0) ? DUR_W'(1) : r_dur_ctr;
  assign w_wr_data    = {r_pend_note, r_pend_oct, w_close_dur};

  assign w_rd_note    = r_rd_data[EW-1 -: 4];
  assign w_rd_oct     = r_rd_data[DUR_W+1 -: 2];
  assign w_rd_dur     = r_rd_data[DUR_W-1:0];
  assign w_hold_done  = w_tick && ((r_hold_cnt + 1'b1) >= r_hold_dur);
  assign w_last       = ({1'b0, r_idx} == (r_count - 1'b1));
  assign w_play_abort = o_playing && i_stop;
  assign w_play_end   = (r_state == S_PHOLD) && !i_stop && w_hold_done && w_last;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_record_en) w_state_next = S_REC;
        else if (i_play_req && (r_count != '0)) w_state_next = S_PLOAD;
      end
      S_REC:   if (i_stop || !i_record_en) w_state_next = S_IDLE;
      S_PLOAD: w_state_next = i_stop ? S_IDLE : S_PWAIT;
      S_PWAIT: w_state_next = i_stop ? S_IDLE : S_PHOLD;
      S_PHOLD: begin
        if (i_stop || w_play_end) w_state_next = S_IDLE;
        else if (w_hold_done) w_state_next = S_PLOAD;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_count[AW-1:0]] <= w_wr_data;
    if (r_state == S_PLOAD) r_rd_data <= r_mem[r_idx];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_idx        <= '0;
      r_tick_cnt   <= '0;
      r_dur_ctr    <= '0;
      r_pend_valid <= 1'b0;
      r_pend_rest  <= 1'b0;
      r_pend_note  <= NOTE_REST;
      r_pend_oct   <= 2'd0;
      r_hold_cnt   <= '0;
      r_hold_dur   <= '0;
      r_note_out   <= NOTE_REST;
      r_octave_out <= 2'd0;
      r_note_load  <= 1'b0;
      r_note_on    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_note_load <= 1'b0;
      // Durations count whole ticks from each state entry or newly opened entry.
      if ((w_state_next != r_state) || w_open || w_tick) r_tick_cnt <= '0;
      else r_tick_cnt <= r_tick_cnt + 1'b1;
      if (w_wr_en) r_count <= r_count + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_record_en) begin
            r_count      <= '0;
            r_pend_valid <= 1'b0;
          end else if (i_play_req) begin
            r_idx <= '0;
          end
        end
        S_REC: begin
          if (w_state_next == S_IDLE) begin
            r_pend_valid <= 1'b0;
          end else if (w_rec_evt) begin
            r_pend_valid <= w_open;
            r_pend_rest  <= w_rel_match;
            r_pend_note  <= w_rel_match ? NOTE_REST : i_key_note;
            r_pend_oct   <= w_rel_match ? 2'd0 : i_key_octave;
            r_dur_ctr    <= '0;
          end else if (w_tick && (r_dur_ctr != DUR_MAX)) begin
            r_dur_ctr <= r_dur_ctr + 1'b1;
          end
        end
        S_PWAIT: begin
          if (!i_stop) begin
            r_note_out   <= w_rd_note;
            r_octave_out <= w_rd_oct;
            r_note_on    <= (w_rd_note != NOTE_REST);
            r_note_load  <= 1'b1;
            r_hold_dur   <= w_rd_dur;
            r_hold_cnt   <= '0;
          end
        end
        S_PHOLD: begin
          if (!i_stop && w_tick) begin
            if (!w_hold_done) r_hold_cnt <= r_hold_cnt + 1'b1;
            else if (!w_last) r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase

      if (w_play_abort || w_play_end) begin
        r_note_out   <= NOTE_REST;
        r_octave_out <= 2'd0;
        r_note_on    <= 1'b0;
        r_note_load  <= 1'b1;
      end
    end
  end

  assign o_note_out   = r_note_out;
  assign o_octave_out = r_octave_out;
  assign o_note_load  = r_note_load;
  assign o_note_on    = r_note_on;
  assign o_recording  = (r_state == S_REC);
  assign o_playing    = (r_state == S_PLOAD) || (r_state == S_PWAIT) || (r_state == S_PHOLD);
  assign o_count      = r_count;
  assign o_full       = w_full;
endmodule

// File: tb/tb_note_sequence_controller.sv
// Bench for note_sequence_controller: event-level model of recording/playback timing
// checked every cycle, plus hand-computed expectations for the directed scenarios.
module tb_note_sequence_controller;
  localparam int DEPTH   = 4;
  localparam int TICK    = 4;
  localparam int DUR_W   = 4;
  localparam int DUR_MAX = (1 << DUR_W) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic       key_release = 1'b0;
  logic [3:0] key_note = 4'd0;
  logic [1:0] key_octave = 2'd0;
  logic       record_en = 1'b0;
  logic       play_req = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] o_note_out;
  logic [1:0] o_octave_out;
  logic       o_note_load;
  logic       o_note_on;
  logic       o_recording;
  logic       o_playing;
  logic [2:0] o_count;
  logic       o_full;

  note_sequence_controller #(.DEPTH(DEPTH), .TICK_DIV(TICK), .DUR_W(DUR_W)) dut (
    .i_clk(clk), .i_reset(reset), .i_key_valid(key_valid), .i_key_release(key_release),
    .i_key_note(key_note), .i_key_octave(key_octave), .i_record_en(record_en),
    .i_play_req(play_req), .i_stop(stop), .o_note_out(o_note_out), .o_octave_out(o_octave_out),
    .o_note_load(o_note_load), .o_note_on(o_note_on), .o_recording(o_recording),
    .o_playing(o_playing), .o_count(o_count), .o_full(o_full)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit m_started = 1'b0;

  // Model: mode 0 idle, 1 recording, 2 playing; pending kind 0 none, 1 note, 2 rest.
  int m_mode = 0;
  int m_count = 0;
  int m_note [DEPTH];
  int m_oct  [DEPTH];
  int m_dur  [DEPTH];
  int pend_kind = 0, pend_note = 0, pend_oct = 0, pend_start = 0;
  int p_idx = 0, p_next = 0;
  bit p_loaded = 1'b0;
  int e_note = 15, e_oct = 0;
  bit e_load = 1'b0, e_on = 1'b0;

  int n_loads;
  int ld_cyc  [8];
  int ld_note [8];

  function automatic void close_pending(int n);
    int t;
    if (pend_kind != 0 && m_count < DEPTH) begin
      t = (n - pend_start - 1) / TICK;
      if (t > DUR_MAX) t = DUR_MAX;
      if (t < 1) t = 1;
      m_note[m_count] = pend_note;
      m_oct[m_count]  = pend_oct;
      m_dur[m_count]  = t;
      m_count++;
    end
    pend_kind = 0;
  endfunction

  function automatic void open_pending(int kind, int note, int oct, int n);
    if (m_count < DEPTH) begin
      pend_kind  = kind;
      pend_note  = note;
      pend_oct   = oct;
      pend_start = n;
    end
  endfunction

  function automatic void end_play();
    m_mode = 0;
    e_note = 15;
    e_oct  = 0;
    e_on   = 1'b0;
    e_load = 1'b1;
  endfunction

  function automatic int entry(int i);
    return (m_note[i] << 8) | (m_oct[i] << 4) | m_dur[i];
  endfunction

  task automatic model_step();
    int kn, ko;
    kn = int'(key_note);
    ko = int'(key_octave);
    cyc++;
    e_load = 1'b0;
    if (reset) begin
      m_started = 1'b1;
      m_mode = 0; m_count = 0; pend_kind = 0;
      e_note = 15; e_oct = 0; e_on = 1'b0;
    end else if (m_mode == 0) begin
      if (record_en) begin
        m_mode = 1; m_count = 0; pend_kind = 0;
      end else if (play_req && m_count > 0) begin
        m_mode = 2; p_idx = 0; p_loaded = 1'b0; p_next = cyc + 2;
      end
    end else if (m_mode == 1) begin
      if (stop) begin
        pend_kind = 0; m_mode = 0;
      end else if (!record_en) begin
        if (pend_kind == 1) close_pending(cyc);
        pend_kind = 0; m_mode = 0;
      end else if (key_valid && kn != 15) begin
        if (!key_release) begin
          close_pending(cyc);
          open_pending(1, kn, ko, cyc);
        end else if (pend_kind == 1 && kn == pend_note && ko == pend_oct) begin
          close_pending(cyc);
          open_pending(2, 15, 0, cyc);
        end
      end
    end else begin
      if (stop) begin
        end_play();
      end else if (cyc == p_next) begin
        if (!p_loaded) begin
          e_note = m_note[p_idx]; e_oct = m_oct[p_idx]; e_on = (e_note != 15);
          e_load = 1'b1; p_loaded = 1'b1; p_next = cyc + TICK * m_dur[p_idx];
        end else if (p_idx == m_count - 1) begin
          end_play();
        end else begin
          p_idx++; p_loaded = 1'b0; p_next = cyc + 2;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [13:0] act, exp;
    @(negedge clk);
    if (m_started) begin
      act = {o_note_out, o_octave_out, o_note_load, o_note_on, o_recording, o_playing, o_full, o_count};
      exp = {4'(e_note), 2'(e_oct), e_load, e_on, (m_mode == 1), (m_mode == 2), (m_count == DEPTH), 3'(m_count)};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle %0d outputs {note,oct,load,on,rec,play,full,count}: got %h expected %h", cyc, act, exp);
      end
    end
  end

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("[TB] check %s = %0d ok", name, act);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(bit rel, int note, int oct);
    key_valid = 1'b1; key_release = rel; key_note = 4'(note); key_octave = 2'(oct);
    step(1);
    key_valid = 1'b0; key_release = 1'b0;
  endtask

  task automatic pulse_play();
    play_req = 1'b1; step(1); play_req = 1'b0;
  endtask

  task automatic watch_play(int stop_after_loads, int max_cyc);
    bit done;
    done = 1'b0;
    n_loads = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (o_note_load) begin
        if (n_loads < 8) begin
          ld_cyc[n_loads]  = cyc;
          ld_note[n_loads] = int'(o_note_out);
        end
        n_loads++;
      end
      if (!o_playing || n_loads == stop_after_loads) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL play_timeout: playback not finished within %0d cycles", max_cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    step(3);
    check("reset_note_out", int'(o_note_out), 15);
    check("reset_count", int'(o_count), 0);
    check("reset_note_load", int'(o_note_load), 0);
    check("reset_note_on", int'(o_note_on), 0);
    reset = 1'b0;
    step(1);

    // C4 held 3 ticks, 2-tick rest, E held 2 ticks
    record_en = 1'b1; step(2);
    key(0, 0, 1); step(12);
    key(1, 0, 1); step(8);
    key(0, 4, 1); step(8);
    record_en = 1'b0; step(2);
    check("rec1_count", int'(o_count), 3);
    check("rec1_full", int'(o_full), 0);
    check("rec1_entry0", entry(0), 'h013);
    check("rec1_entry1", entry(1), 'hF02);
    check("rec1_entry2", entry(2), 'h412);

    pulse_play();
    watch_play(99, 400);
    check("play1_loads", n_loads, 4);
    check("play1_note0", ld_note[0], 0);
    check("play1_note1", ld_note[1], 15);
    check("play1_note2", ld_note[2], 4);
    check("play1_note3", ld_note[3], 15);
    check("play1_gap01", ld_cyc[1] - ld_cyc[0], 14);
    check("play1_gap12", ld_cyc[2] - ld_cyc[1], 10);
    check("play1_gap23", ld_cyc[3] - ld_cyc[2], 8);
    step(1);

    // Six press/release pairs overflow a 4-entry RAM
    record_en = 1'b1; step(2);
    for (int i = 0; i < 6; i++) begin
      key(0, i, 0); step(2);
      key(1, i, 0); step(2);
    end
    record_en = 1'b0; step(2);
    check("full_count", int'(o_count), 4);
    check("full_flag", int'(o_full), 1);
    check("full_entry2", entry(2), 'h101);
    check("full_entry3", entry(3), 'hF01);

    // Stop during the hold of entry 1
    pulse_play();
    watch_play(2, 200);
    step(2);
    stop = 1'b1; step(1); stop = 1'b0;
    check("stop_playing", int'(o_playing), 0);
    check("stop_note_out", int'(o_note_out), 15);
    check("stop_note_on", int'(o_note_on), 0);
    check("stop_note_load", int'(o_note_load), 1);
    step(2);

    // Saturating long note, then one-tick press/release
    record_en = 1'b1; step(1);
    key(0, 5, 2); step(330);
    key(1, 5, 2);
    key(0, 6, 3);
    key(1, 6, 3);
    record_en = 1'b0; step(2);
    check("sat_count", int'(o_count), 3);
    check("sat_entry0", entry(0), 'h52F);
    check("short_entry2", entry(2), 'h631);
    pulse_play();
    watch_play(99, 400);
    check("sat_loads", n_loads, 4);
    check("sat_note0", ld_note[0], 5);
    check("sat_gap01", ld_cyc[1] - ld_cyc[0], 62);
    step(1);

    // record_en and play_req together: record wins
    record_en = 1'b1; play_req = 1'b1; step(1); play_req = 1'b0;
    check("both_recording", int'(o_recording), 1);
    check("both_playing", int'(o_playing), 0);
    check("both_count", int'(o_count), 0);
    key(0, 7, 1); step(3);
    reset = 1'b1; record_en = 1'b0; step(1);
    check("midrst_recording", int'(o_recording), 0);
    check("midrst_count", int'(o_count), 0);
    check("midrst_note_out", int'(o_note_out), 15);
    reset = 1'b0; step(1);

    // stop beats both key_valid and a falling record_en
    record_en = 1'b1; step(1);
    key(0, 2, 1); step(5);
    stop = 1'b1; record_en = 1'b0; key_valid = 1'b1; key_note = 4'd3; key_release = 1'b0;
    step(1);
    stop = 1'b0; key_valid = 1'b0;
    check("stopkey_count", int'(o_count), 0);
    check("stopkey_recording", int'(o_recording), 0);

    // Keys outside REC and play_req with an empty RAM are ignored
    key(0, 1, 1); step(1);
    check("idlekey_count", int'(o_count), 0);
    pulse_play(); step(1);
    check("empty_play_playing", int'(o_playing), 0);
    check("empty_play_load", int'(o_note_load), 0);
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
